// File: rtl/spi_slv16.sv
// spi_slv16: 16-bit SPI responder (SCLK idles high, MSB first, frame closed by SS_n rise).
// Optional SPI_SLV16_FRAME_ERR_EN adds the sticky frm_err output.
module spi_slv16 #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [15:0] tx_data,
   input  logic        wrt_tx,
   output logic [15:0] rd_data,
   output logic        cmd_rdy,
   input  logic        clr_rdy
`ifdef SPI_SLV16_FRAME_ERR_EN
   ,
   output logic        frm_err
`endif
);

   localparam int unsigned DW = 16;
   localparam int unsigned CW = 5;
   localparam logic [CW-1:0] FULL_CNT = CW'(DW);

   typedef enum logic {IDLE, XFER} state_t;

   // Synchronizers, history flops and registered edge pulses
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic ss_hist_q, ss_hist_d;
   logic sclk_hist_q, sclk_hist_d;
   logic mosi_hist_q, mosi_hist_d;
   logic sclk_rise_q, sclk_rise_d;
   logic sclk_fall_q, sclk_fall_d;
   logic ss_fall_q, ss_fall_d;
   logic ss_rise_q, ss_rise_d;

   // Protocol state and datapath
   state_t        state_q, state_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] tx_buf_q, tx_buf_d;
   logic [DW-1:0] tx_shft_q, tx_shft_d;
   logic [DW-1:0] rx_shft_q, rx_shft_d;
   logic [DW-1:0] rd_data_q, rd_data_d;
   logic          cmd_rdy_q, cmd_rdy_d;
   logic          miso_q, miso_d;
`ifdef SPI_SLV16_FRAME_ERR_EN
   logic          frm_err_q, frm_err_d;
`endif

   always_comb begin
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      ss_hist_d   = ss_sync_q[SYNC_STAGES-1];
      sclk_hist_d = sclk_sync_q[SYNC_STAGES-1];
      mosi_hist_d = mosi_sync_q[SYNC_STAGES-1];
      sclk_rise_d = sclk_sync_q[SYNC_STAGES-1] & ~sclk_hist_q;
      sclk_fall_d = ~sclk_sync_q[SYNC_STAGES-1] & sclk_hist_q;
      ss_fall_d   = ~ss_sync_q[SYNC_STAGES-1] & ss_hist_q;
      ss_rise_d   = ss_sync_q[SYNC_STAGES-1] & ~ss_hist_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync_q   <= '1;
         sclk_sync_q <= '1;
         mosi_sync_q <= '0;
         ss_hist_q   <= 1'b1;
         sclk_hist_q <= 1'b1;
         mosi_hist_q <= 1'b0;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         ss_fall_q   <= 1'b0;
         ss_rise_q   <= 1'b0;
      end else begin
         ss_sync_q   <= ss_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         ss_hist_q   <= ss_hist_d;
         sclk_hist_q <= sclk_hist_d;
         mosi_hist_q <= mosi_hist_d;
         sclk_rise_q <= sclk_rise_d;
         sclk_fall_q <= sclk_fall_d;
         ss_fall_q   <= ss_fall_d;
         ss_rise_q   <= ss_rise_d;
      end
   end

   // mosi_hist_q lines up with the registered sclk_rise pulse
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      tx_buf_d  = tx_buf_q;
      tx_shft_d = tx_shft_q;
      rx_shft_d = rx_shft_q;
      rd_data_d = rd_data_q;
      cmd_rdy_d = cmd_rdy_q;
`ifdef SPI_SLV16_FRAME_ERR_EN
      frm_err_d = frm_err_q;
      if (clr_rdy) frm_err_d = 1'b0;
`endif
      if (wrt_tx)  tx_buf_d  = tx_data;
      if (clr_rdy) cmd_rdy_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (ss_fall_q) begin
               state_d   = XFER;
               tx_shft_d = wrt_tx ? tx_data : tx_buf_q;
               rx_shft_d = '0;
               bit_cnt_d = '0;
               cmd_rdy_d = 1'b0;
`ifdef SPI_SLV16_FRAME_ERR_EN
               frm_err_d = 1'b0;
`endif
            end
         end
         XFER: begin
            if (sclk_rise_q) begin
               rx_shft_d = {rx_shft_q[DW-2:0], mosi_hist_q};
               if (bit_cnt_q != FULL_CNT) begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
`ifdef SPI_SLV16_FRAME_ERR_EN
               else begin
                  frm_err_d = 1'b1;
               end
`endif
            end
            // The fall before the first rise is the master's front porch
            if (sclk_fall_q && (bit_cnt_q != '0)) begin
               tx_shft_d = {tx_shft_q[DW-2:0], 1'b0};
            end
            if (ss_rise_q) begin
               state_d = IDLE;
               if (bit_cnt_q == FULL_CNT) begin
                  rd_data_d = rx_shft_q;
                  cmd_rdy_d = 1'b1;
               end
`ifdef SPI_SLV16_FRAME_ERR_EN
               else begin
                  frm_err_d = 1'b1;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      miso_d = (state_d == XFER) ? tx_shft_d[DW-1] : 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         tx_buf_q  <= '0;
         tx_shft_q <= '0;
         rx_shft_q <= '0;
         rd_data_q <= '0;
         cmd_rdy_q <= 1'b0;
         miso_q    <= 1'b0;
`ifdef SPI_SLV16_FRAME_ERR_EN
         frm_err_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         tx_buf_q  <= tx_buf_d;
         tx_shft_q <= tx_shft_d;
         rx_shft_q <= rx_shft_d;
         rd_data_q <= rd_data_d;
         cmd_rdy_q <= cmd_rdy_d;
         miso_q    <= miso_d;
`ifdef SPI_SLV16_FRAME_ERR_EN
         frm_err_q <= frm_err_d;
`endif
      end
   end

   assign MISO    = miso_q;
   assign rd_data = rd_data_q;
   assign cmd_rdy = cmd_rdy_q;
`ifdef SPI_SLV16_FRAME_ERR_EN
   assign frm_err = frm_err_q;
`endif

endmodule
